// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   state_e     : controller FSM states
//   mem_size_e  : access size encoding from the EX stage (11 behaves as WORD)
//   LANES/LANE_W: byte-lane geometry of the 32-bit data bus
//   is_misaligned(): true when an access crosses its natural boundary
package lsu_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int DATA_W = LANES * LANE_W;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCESS  = 2'b01,
    ACCESS2 = 2'b10,
    RESP    = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_e;

  // Half at offset 3 spills into the next word; any non-zero word offset does.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (mem_size_e'(size))
      BYTE:    return 1'b0;
      HALF:    return off == 2'b11;
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane steering for the LSU.
//   size/zext/offset : latched access attributes
//   wdata            : right-aligned store data
//   rdata_lo/hi      : first and second bus words (hi only matters on a split)
//   be               : 8-bit enable over two consecutive words ([3:0] first)
//   wdata_sh         : store data shifted across the same two-word window
//   rdata            : load result shifted down and sign/zero extended
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]          size,
  input  logic                zext,
  input  logic [1:0]          offset,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   rdata_lo,
  input  logic [DATA_W-1:0]   rdata_hi,
  output logic [2*LANES-1:0]  be,
  output logic [2*DATA_W-1:0] wdata_sh,
  output logic [DATA_W-1:0]   rdata
);

  logic [LANES-1:0]  mask;
  logic [4:0]        sh;
  logic [DATA_W-1:0] raw;

  assign sh = {offset, 3'b000};

  always_comb begin
    mask = 4'b1111;
    case (mem_size_e'(size))
      BYTE:    mask = 4'b0001;
      HALF:    mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    // Working over a two-word window lets split accesses fall out of the
    // same shift: the upper half is simply the second bus beat.
    be       = {4'b0000, mask} << offset;
    wdata_sh = {32'b0, wdata} << sh;
    raw      = 32'({rdata_hi, rdata_lo} >> sh);

    rdata = raw;
    case (mem_size_e'(size))
      BYTE:    rdata = zext ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      HALF:    rdata = zext ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: rdata = raw;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller between the EX stage and a word memory bus.
//   req_*      : request from EX, held until done
//   stall      : pipeline hold, req_valid && !done
//   done/rdata/misalign : one-cycle completion with load data / fault flag
//   bus_*      : single-beat request/accept memory port, word aligned
// Optional feature: define LSU_MISALIGN_SPLIT_EN to split misaligned accesses
// into two word transactions instead of faulting.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              misalign,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  state_e            state, state_n;
  logic [1:0]        size_q;
  logic              zext_q, we_q, mis_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q, lo_q;
  logic              accept, fault, cap_lo, cap;
  logic              split, second;
  logic [ADDR_W-1:0] base;
  logic [7:0]        be8;
  logic [63:0]       wsh;
  logic [31:0]       ld_data;

  assign split  = SPLIT_EN && is_misaligned(size_q, addr_q[1:0]);
  assign second = (state == ACCESS2);
  assign base   = {addr_q[ADDR_W-1:2], 2'b00};

  lsu_align u_align (
    .size     (size_q),
    .zext     (zext_q),
    .offset   (addr_q[1:0]),
    .wdata    (wdata_q),
    .rdata_lo (second ? lo_q : bus_rdata),
    .rdata_hi (bus_rdata),
    .be       (be8),
    .wdata_sh (wsh),
    .rdata    (ld_data)
  );

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    fault   = 1'b0;
    cap_lo  = 1'b0;
    cap     = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        accept = 1'b1;
        if (!SPLIT_EN && is_misaligned(req_size, req_addr[1:0])) begin
          fault   = 1'b1;
          state_n = RESP;
        end else begin
          state_n = ACCESS;
        end
      end
      ACCESS: if (bus_ready) begin
        if (split) begin
          cap_lo  = 1'b1;
          state_n = ACCESS2;
        end else begin
          cap     = 1'b1;
          state_n = RESP;
        end
      end
      ACCESS2: if (bus_ready) begin
        cap     = 1'b1;
        state_n = RESP;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      size_q  <= '0;
      zext_q  <= 1'b0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      lo_q    <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        size_q  <= req_size;
        zext_q  <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        we_q    <= req_write;
        mis_q   <= fault;
        rdata_q <= '0;
      end
      if (cap_lo) lo_q <= bus_rdata;
      if (cap && !we_q) rdata_q <= ld_data;
    end
  end

  // Bus fields are derived from latched state, so they cannot move while
  // waiting for bus_ready; they read as zero outside an access.
  assign bus_valid = (state == ACCESS) || second;
  assign bus_we    = bus_valid && we_q;
  assign bus_addr  = !bus_valid ? '0 : (second ? base + ADDR_W'(4) : base);
  assign bus_be    = !bus_valid ? '0 : (second ? be8[7:4] : be8[3:0]);
  assign bus_wdata = !bus_valid ? '0 : (second ? wsh[63:32] : wsh[31:0]);

  assign done     = (state == RESP);
  assign rdata    = rdata_q;
  assign misalign = mis_q;
  assign stall    = req_valid && !done;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        stall, done, misalign, bus_valid, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;

  lsu_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .done(done), .rdata(rdata),
    .misalign(misalign), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; } bus_t;
  typedef struct { logic chk_rd; logic [31:0] rd; logic mis; } rsp_t;

  bus_t        bus_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] rword[$];
  int          wait_n = 0;
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_bus(input logic [31:0] a, input logic [3:0] be, input logic we, input logic [31:0] wd);
    bus_t b;
    b.addr = a; b.be = be; b.we = we; b.wdata = wd;
    bus_q.push_back(b);
  endtask

  task automatic exp_rsp(input logic c, input logic [31:0] rd, input logic mis);
    rsp_t r;
    r.chk_rd = c; r.rd = rd; r.mis = mis;
    rsp_q.push_back(r);
  endtask

  // Memory model: optional wait states on the first beat, then ready.
  always @(posedge clk) begin
    logic acc;
    acc = bus_valid && bus_ready;
    #1;
    if (acc && rword.size() > 0) void'(rword.pop_front());
    if (bus_valid && wait_n > 0) begin
      bus_ready = 1'b0;
      wait_n--;
    end else begin
      bus_ready = bus_valid;
    end
    bus_rdata = (rword.size() > 0) ? rword[0] : 32'h0;
  end

  // Monitor: bus fields checked every valid cycle against the head entry
  // (so they must stay put while waiting); responses popped on done.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_valid) begin
        if (bus_q.size() == 0) chk("bus_valid_unexpected", {31'b0, bus_valid}, 32'h0);
        else begin
          bus_t b;
          logic [31:0] m;
          b = bus_q[0];
          m = {{8{b.be[3]}}, {8{b.be[2]}}, {8{b.be[1]}}, {8{b.be[0]}}};
          chk("bus_addr", bus_addr, b.addr);
          chk("bus_be", {28'b0, bus_be}, {28'b0, b.be});
          chk("bus_we", {31'b0, bus_we}, {31'b0, b.we});
          if (b.we) chk("bus_wdata", bus_wdata & m, b.wdata & m);
          if (bus_ready) void'(bus_q.pop_front());
        end
      end
      if (done) begin
        if (rsp_q.size() == 0) chk("done_unexpected", {31'b0, done}, 32'h0);
        else begin
          rsp_t r;
          r = rsp_q.pop_front();
          chk("misalign", {31'b0, misalign}, {31'b0, r.mis});
          if (r.chk_rd) chk("rdata", rdata, r.rd);
        end
      end
    end
  end

  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, input int lat);
    int n;
    @(posedge clk); #2;
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    n = 1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #2;
      n++;
      if (n == 2) begin
        // Request already latched: garbage here must not reach the bus.
        req_write = ~w; req_size = 2'b00; req_unsigned = ~u;
        req_addr = 32'h0000_0FF3; req_wdata = 32'h5A5A_5A5A;
      end
      if (done) break;
      chk("stall_busy", {31'b0, stall}, 32'h1);
    end
    chk("latency", n, lat);
    chk("stall_done", {31'b0, stall}, 32'h0);
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_valid", {31'b0, bus_valid}, 32'h0);
    chk("rst_bus_we", {31'b0, bus_we}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_misalign", {31'b0, misalign}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_be", {28'b0, bus_be}, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    @(negedge clk); rst = 1'b0;

    // lb 0x103 -> lane 3, sign extended
    rword.push_back(32'h8000_0000);
    exp_bus(32'h100, 4'b1000, 1'b0, 32'h0); exp_rsp(1, 32'hFFFF_FF80, 0);
    do_req(0, 2'b00, 0, 32'h103, 32'h0, 3);
    // sh 0x202
    exp_bus(32'h200, 4'b1100, 1'b1, 32'hBEEF_0000); exp_rsp(0, 32'h0, 0);
    do_req(1, 2'b01, 0, 32'h202, 32'h0000_BEEF, 3);
    // lw 0x100 with 4 wait states
    rword.push_back(32'h1234_5678); wait_n = 4;
    exp_bus(32'h100, 4'b1111, 1'b0, 32'h0); exp_rsp(1, 32'h1234_5678, 0);
    do_req(0, 2'b10, 0, 32'h100, 32'h0, 7);
    // lbu 0x102, lb 0x101 positive
    rword.push_back(32'h00AB_0000);
    exp_bus(32'h100, 4'b0100, 1'b0, 32'h0); exp_rsp(1, 32'h0000_00AB, 0);
    do_req(0, 2'b00, 1, 32'h102, 32'h0, 3);
    rword.push_back(32'h0000_7F00);
    exp_bus(32'h100, 4'b0010, 1'b0, 32'h0); exp_rsp(1, 32'h0000_007F, 0);
    do_req(0, 2'b00, 0, 32'h101, 32'h0, 3);
    // lh / lhu 0x102
    rword.push_back(32'h8001_1234);
    exp_bus(32'h100, 4'b1100, 1'b0, 32'h0); exp_rsp(1, 32'hFFFF_8001, 0);
    do_req(0, 2'b01, 0, 32'h102, 32'h0, 3);
    rword.push_back(32'h8001_1234);
    exp_bus(32'h100, 4'b1100, 1'b0, 32'h0); exp_rsp(1, 32'h0000_8001, 0);
    do_req(0, 2'b01, 1, 32'h102, 32'h0, 3);
    // sb 0x301, sw 0x400
    exp_bus(32'h300, 4'b0010, 1'b1, 32'h0000_A500); exp_rsp(0, 32'h0, 0);
    do_req(1, 2'b00, 0, 32'h301, 32'h0000_00A5, 3);
    exp_bus(32'h400, 4'b1111, 1'b1, 32'hDEAD_BEEF); exp_rsp(0, 32'h0, 0);
    do_req(1, 2'b10, 0, 32'h400, 32'hDEAD_BEEF, 3);
    // size 11 acts as word; word ignores req_unsigned
    rword.push_back(32'hCAFE_F00D);
    exp_bus(32'h200, 4'b1111, 1'b0, 32'h0); exp_rsp(1, 32'hCAFE_F00D, 0);
    do_req(0, 2'b11, 0, 32'h200, 32'h0, 3);
    rword.push_back(32'h8000_0000);
    exp_bus(32'h200, 4'b1111, 1'b0, 32'h0); exp_rsp(1, 32'h8000_0000, 0);
    do_req(0, 2'b10, 1, 32'h200, 32'h0, 3);

`ifdef LSU_MISALIGN_SPLIT_EN
    rword.push_back(32'hAABB_CCDD); rword.push_back(32'h1122_3344);
    exp_bus(32'h100, 4'b1110, 1'b0, 32'h0); exp_bus(32'h104, 4'b0001, 1'b0, 32'h0);
    exp_rsp(1, 32'h44AA_BBCC, 0);
    do_req(0, 2'b10, 0, 32'h101, 32'h0, 4);
    rword.push_back(32'h1100_0000); rword.push_back(32'h0000_0022);
    exp_bus(32'h100, 4'b1000, 1'b0, 32'h0); exp_bus(32'h104, 4'b0001, 1'b0, 32'h0);
    exp_rsp(1, 32'h0000_2211, 0);
    do_req(0, 2'b01, 0, 32'h103, 32'h0, 4);
    rword.push_back(32'hAABB_0000); rword.push_back(32'h0000_CCDD);
    exp_bus(32'hFFFF_FFFC, 4'b1100, 1'b0, 32'h0); exp_bus(32'h0, 4'b0011, 1'b0, 32'h0);
    exp_rsp(1, 32'hCCDD_AABB, 0);
    do_req(0, 2'b10, 0, 32'hFFFF_FFFE, 32'h0, 4);
    exp_bus(32'h200, 4'b1000, 1'b1, 32'h4400_0000); exp_bus(32'h204, 4'b0111, 1'b1, 32'h0011_2233);
    exp_rsp(0, 32'h0, 0);
    do_req(1, 2'b10, 0, 32'h203, 32'h1122_3344, 4);
`else
    exp_rsp(1, 32'h0, 1); do_req(0, 2'b10, 0, 32'h101, 32'h0, 2);
    exp_rsp(1, 32'h0, 1); do_req(0, 2'b01, 0, 32'h103, 32'h0, 2);
    exp_rsp(1, 32'h0, 1); do_req(0, 2'b10, 0, 32'hFFFF_FFFE, 32'h0, 2);
    exp_rsp(0, 32'h0, 1); do_req(1, 2'b10, 0, 32'h203, 32'h1122_3344, 2);
`endif

    // Reset while waiting for bus_ready
    wait_n = 10;
    exp_bus(32'h100, 4'b1111, 1'b0, 32'h0);
    @(posedge clk); #2;
    req_write = 0; req_size = 2'b10; req_unsigned = 0; req_addr = 32'h100; req_valid = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("wait_bus_valid", {31'b0, bus_valid}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_bus_valid", {31'b0, bus_valid}, 32'h0);
    chk("rst_mid_done", {31'b0, done}, 32'h0);
    bus_q.delete(); rword.delete(); wait_n = 0; req_valid = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Back to normal after reset
    rword.push_back(32'h0000_FFFF);
    exp_bus(32'h100, 4'b0011, 1'b0, 32'h0); exp_rsp(1, 32'h0000_FFFF, 0);
    do_req(0, 2'b01, 1, 32'h100, 32'h0, 3);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drain", bus_q.size() + rsp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, byte-address width of req_addr and bus_addr.
REQ-002 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-003 SHALL have ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  load/store pending from EX stage (mem_read|mem_write); held until done.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00=byte, 01=half, 10=word; 11 treated as word.
- req_unsigned  in  1  1=zero-extend load, 0=sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- stall  out  1  pipeline hold.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result, valid with done.
- misalign  out  1  misaligned-access fault, valid with done.
- bus_valid  out  1  memory request.
- bus_ready  in  1  memory accept; bus_rdata valid same cycle.
- bus_we  out  1  write strobe.
- bus_addr  out  ADDR_W  word-aligned address (bits [1:0]=0).
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-shifted store data.
- bus_rdata  in  32  read word.

Function
REQ-004 SHALL implement FSM IDLE, ACCESS, ACCESS2, RESP.
REQ-005 IDLE: on req_valid, latch size/unsigned/addr/wdata/write; go to ACCESS, or RESP with fault if misaligned and split disabled.
REQ-006 Misaligned SHALL mean half with addr[1:0]=3, or word with addr[1:0]!=0.
REQ-007 ACCESS/ACCESS2: bus_valid=1 with addr/be/we/wdata stable until bus_ready; no change while waiting.
REQ-008 On bus_ready in ACCESS: go to ACCESS2 if a split is required, else RESP; loads capture bus_rdata at that edge.
REQ-009 RESP: done=1 for exactly one cycle, then IDLE; no new request accepted in RESP.
REQ-010 stall SHALL equal req_valid && !done (combinational).
REQ-011 Aligned access latency SHALL be 3 cycles with bus_ready tied high (accept, access, resp).
REQ-012 bus_be: byte 0001<<a[1:0]; half 0011<<a[1:0]; word 1111.
REQ-013 Store data SHALL be shifted to lane a[1:0]*8; unused lanes are don't-care.
REQ-014 Loads SHALL shift right by a[1:0]*8 and sign/zero-extend per req_unsigned; word loads ignore req_unsigned.
REQ-015 Fault responses SHALL issue no bus transaction, set misalign=1 and rdata=0.
REQ-016 Changes on req_* after acceptance SHALL be ignored until IDLE.

Reset
REQ-017 rst SHALL force state IDLE and set bus_valid, bus_we, done, misalign, stall-internal latches to 0; rdata, bus_addr, bus_be, bus_wdata to 0.
REQ-018 rst mid-transaction SHALL drop bus_valid immediately and discard the access; no done pulse.

Configuration
REQ-019 With LSU_MISALIGN_SPLIT_EN defined, misaligned accesses SHALL split into two word transactions: first at addr&~3 with lanes offset..3, second at (addr&~3)+4 (wrapping 0xFFFFFFFC->0x0) with remaining lanes; loads merge both before extension; misalign stays 0.
REQ-020 Without LSU_MISALIGN_SPLIT_EN, ACCESS2 SHALL be unreachable and misaligned accesses fault per REQ-015.

Structure
REQ-021 Package lsu_pkg SHALL hold the state enum, mem_size_e (BYTE=00, HALF=01, WORD=10) and lane-width constants.
REQ-022 Byte-lane shift/extend SHALL be a combinational sub-module lsu_align instantiated by lsu_ctrl.

Verification
REQ-023 lb addr=0x103, bus_rdata=0x80000000, ready high -> bus_be=1000, rdata=0xFFFFFF80, done at cycle 3.
REQ-024 sh addr=0x202, wdata=0x0000BEEF -> bus_be=1100, bus_wdata[31:16]=0xBEEF, bus_we=1.
REQ-025 lw addr=0x100, bus_ready low 4 cycles -> bus_* stable, stall=1, done 1 cycle after ready.
REQ-026 lw addr=0x101, macro off -> no bus_valid, misalign=1, done=1, rdata=0.
REQ-027 lw addr=0xFFFFFFFE, macro on, words 0xAABB0000 then 0x0000CCDD -> second bus_addr=0x0, rdata=0xCCDDAABB.
REQ-028 rst asserted during ACCESS wait -> bus_valid=0 same cycle, state IDLE, no done.
